// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic tile sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADB  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    localparam int DEFAULT_DIM = 8;

    // Shift cycles needed after the last A row for the skewed wavefront to clear the array.
    function automatic int drain_cycles(input int dim);
        return 2 * dim - 1;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer: loads B weights, streams A rows through the skew FIFOs,
// drains the array with zero injection and pulses done when results are final.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int DIM       = DEFAULT_DIM,
    parameter int DRAIN_CYC = drain_cycles(DIM),
    parameter int CNT_W     = $clog2(2 * DIM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   b_valid,
    output logic                   b_ready,
    output logic                   b_wr_en,
    output logic [$clog2(DIM)-1:0] b_wr_row,
    input  logic                   a_valid,
    output logic                   a_ready,
    output logic [$clog2(DIM)-1:0] a_row_idx,
    output logic                   shift_en,
    output logic                   inject_zero,
    output logic                   busy,
    output logic                   done
);

    localparam int ROW_W = $clog2(DIM);
    localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_CYC - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b_ready     = 1'b0;
        b_wr_en     = 1'b0;
        b_wr_row    = '0;
        a_ready     = 1'b0;
        a_row_idx   = '0;
        shift_en    = 1'b0;
        inject_zero = 1'b0;
        done        = 1'b0;
        busy        = (state_q != IDLE);

        // Abort takes priority over any handshake: every strobe stays low this cycle.
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOADB;
                        cnt_d   = '0;
                    end
                end
                LOADB: begin
                    b_ready  = 1'b1;
                    b_wr_row = cnt_q[ROW_W-1:0];
                    if (b_valid) begin
                        b_wr_en = 1'b1;
                        if (cnt_q == LAST_ROW) begin
                            state_d = STREAM;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    // Shift only on an accepted row so no bubble enters the skewed pipeline.
                    a_ready   = 1'b1;
                    a_row_idx = cnt_q[ROW_W-1:0];
                    if (a_valid) begin
                        shift_en = 1'b1;
                        if (cnt_q == LAST_ROW) begin
                            state_d = DRAIN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    shift_en    = 1'b1;
                    inject_zero = 1'b1;
                    if (cnt_q == LAST_DRAIN) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencer for one matrix-multiply tile on the DIM x DIM systolic array. It loads DIM rows of B into array weight registers over a valid/ready handshake. It then streams DIM rows of A through the per-lane skew delay FIFOs and drains the pipeline with zero injection. It drives the shift enable of every skew FIFO and array stage, and pulses done when the result tile is final. It sits between the host-facing load interface and the FIFO/array datapath.

Parameters:
DIM, 8, array dimension; also number of A/B rows per tile and number of skew-FIFO lanes
DRAIN_CYC, 2*DIM-1, shift cycles after the last A row before results are final
CNT_W, $clog2(2*DIM), width of the internal beat/drain counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a tile; honoured in IDLE only
abort  in  1  return to IDLE next cycle from any state
b_valid  in  1  B row available
b_ready  out  1  controller accepts a B row
b_wr_en  out  1  write B row into array weights (= b_valid & b_ready)
b_wr_row  out  $clog2(DIM)  weight row index for the write
a_valid  in  1  A row available
a_ready  out  1  controller accepts an A row
a_row_idx  out  $clog2(DIM)  index of the A row being accepted
shift_en  out  1  common enable to all skew FIFOs and array stages
inject_zero  out  1  mux select: FIFO inputs take 0 instead of A data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: tile result valid in array accumulators

Behaviour:
- One clock; reset is asynchronous and active-high. With rst high, state=IDLE, counter=0, and all outputs 0.
- States: IDLE, LOADB, STREAM, DRAIN, DONE. Encoding is a package enum.
- IDLE: all outputs 0. start=1 -> LOADB with counter cleared. The array accumulator clear is derived from that transition by the datapath; it is not a port here.
- LOADB: b_ready=1. Each cycle with b_valid=1: b_wr_en=1, b_wr_row=counter, counter++. The handshake with counter=DIM-1 -> STREAM, counter cleared. b_valid=0 stalls: no write, no count.
- STREAM: a_ready=1. A handshake (a_valid=1) gives shift_en=1, inject_zero=0, a_row_idx=counter, counter++. With no handshake, shift_en=0 and the FIFOs hold; bubbles never enter the pipeline. The handshake with counter=DIM-1 -> DRAIN, counter cleared.
- DRAIN: shift_en=1 and inject_zero=1 every cycle, with no stalls. counter counts 0..DRAIN_CYC-1. The cycle with counter=DRAIN_CYC-1 -> DONE.
- DONE: done=1 for exactly one cycle, busy=1, shift_en=0 -> IDLE.
- Latency: the minimum tile takes 1 + DIM + DIM + DRAIN_CYC + 1 cycles from start to done-clear. With DIM=4 that is 17 cycles; done is high in cycle 16 after start.
- Outputs are combinational from state, counter and the valid inputs. The ready signals depend only on state, with no combinational valid->ready path.
- abort=1 in any non-IDLE state -> IDLE next cycle, counter cleared.
  - abort wins over a same-cycle handshake: ready is forced 0, so there is no write and no shift.
  - done is not asserted after abort.
  - abort in IDLE has no effect.
- start outside IDLE is ignored. start and abort together in IDLE -> LOADB; abort is ignored in IDLE.
- Counter wrap never occurs: every terminal value is compared explicitly.
- b_wr_row and a_row_idx are 0 when their ready signal is 0.

Decomposition:
- Package systolic_pkg holds: the state enum seq_state_t {IDLE, LOADB, STREAM, DRAIN, DONE}, the default DIM, and the function drain_cycles(dim) = 2*dim-1.
- This block is a single module. The skew FIFO bank and array are instantiated by the top-level, not here.
- Shared counter: one CNT_W-bit counter reused across LOADB, STREAM and DRAIN.

Test Plan:
- DIM=4. Pulse start, hold b_valid and a_valid high -> b_wr_row 0,1,2,3 on cycles 1-4; a_row_idx 0..3 with shift_en on cycles 5-8; inject_zero and shift_en on cycles 9-15; done on cycle 16 only; busy low on cycle 17.
- Stalls: drop a_valid for 2 cycles after the 2nd A row -> shift_en=0 for those 2 cycles, a_row_idx holds at 2, and done is delayed by exactly 2 cycles. Repeat with b_valid for LOADB.
- abort on drain cycle 3 -> IDLE next cycle, no done pulse, shift_en=0. A following start runs a full clean tile with b_wr_row starting at 0.
- abort in the same cycle as a B handshake -> b_ready=0 and b_wr_en=0 that cycle, then IDLE.
- start pulsed during STREAM -> ignored; the timing matches the first scenario.
- Assert rst asynchronously mid-DRAIN, between clock edges -> all outputs 0 immediately and state=IDLE. After release, start again -> the nominal 17-cycle sequence.
